// File: rtl/rf_sequencer.sv
// rtl/rf_sequencer.sv - receptive-field table sequencer feeding the DAC driver, handshaking each field with the ADC
// Optional zero-pattern skipping is enabled by defining RF_SKIP_ZERO_EN.
module rf_sequencer #(
    parameter int         DWELL_FRAMES = 2,
    parameter int         ACK_TIMEOUT  = 255,
    parameter logic [1:0] SAMPLE_ST    = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_state,
    input  logic [1:0] system_state,
    input  logic       tbl_we,
    input  logic [3:0] tbl_addr,
    input  logic [3:0] tbl_wdata,
    input  logic       frame_done,
    input  logic       adc_ack,
    output logic [3:0] field,
    output logic [4:0] cnt_RF,
    output logic       adc_trig,
    output logic       rf_done,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DWELL,
        S_TRIG,
        S_WAIT_ACK,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL_FRAMES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(ACK_TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] tbl_q [16];
    logic [3:0] tbl_d [16];
    logic [3:0] field_q, field_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] dwell_q, dwell_d;
    logic [7:0] tmo_q, tmo_d;
    logic       trig_q, trig_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       active;
    logic [4:0] cnt_inc;
    logic [3:0] next_pat;
    logic       skip_first;
    logic       skip_next;

    assign active   = key_state && (system_state == SAMPLE_ST);
    assign cnt_inc  = cnt_q + 5'd1;
    assign next_pat = tbl_q[cnt_inc[3:0]];

`ifdef RF_SKIP_ZERO_EN
    assign skip_first = (tbl_q[0] == 4'b0000);
    assign skip_next  = (next_pat == 4'b0000);
`else
    assign skip_first = 1'b0;
    assign skip_next  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        tmo_d   = tmo_q;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        for (int i = 0; i < 16; i++) begin
            tbl_d[i] = tbl_q[i];
        end
        // The table is frozen for the whole time the scan is enabled.
        if (tbl_we && !active) begin
            tbl_d[tbl_addr] = tbl_wdata;
        end

        if (!active) begin
            state_d = S_IDLE;
            field_d = 4'd0;
            cnt_d   = 5'd0;
            dwell_d = 4'd0;
            tmo_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    err_d   = 1'b0;
                    cnt_d   = 5'd0;
                    dwell_d = 4'd0;
                    if (skip_first) begin
                        field_d = 4'd0;
                        state_d = S_STEP;
                    end else begin
                        field_d = tbl_q[0];
                        state_d = S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (frame_done) begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_d = 4'd0;
                            trig_d  = 1'b1;
                            state_d = S_TRIG;
                        end else begin
                            dwell_d = dwell_q + 4'd1;
                        end
                    end
                end
                S_TRIG: begin
                    tmo_d   = 8'd0;
                    state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    tmo_d = tmo_q + 8'd1;
                    if (adc_ack) begin
                        state_d = S_STEP;
                    end else if (tmo_q + 8'd1 == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_STEP;
                    end
                end
                S_STEP: begin
                    cnt_d   = cnt_inc;
                    dwell_d = 4'd0;
                    if (cnt_inc[4]) begin
                        field_d = 4'd0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (skip_next) begin
                        field_d = 4'd0;
                    end else begin
                        field_d = next_pat;
                        state_d = S_DWELL;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            field_q <= 4'd0;
            cnt_q   <= 5'd0;
            dwell_q <= 4'd0;
            tmo_q   <= 8'd0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                tbl_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            tmo_q   <= tmo_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < 16; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    assign field       = field_q;
    assign cnt_RF      = cnt_q;
    assign adc_trig    = trig_q;
    assign rf_done     = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb/tb_rf_sequencer.sv - scoreboard bench for rf_sequencer: expected trig/done events queued by stimulus, popped by a monitor
module tb_rf_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_state = 1'b0;
    logic [1:0] system_state = 2'b00;
    logic       tbl_we = 1'b0;
    logic [3:0] tbl_addr = 4'd0;
    logic [3:0] tbl_wdata = 4'd0;
    logic       frame_done = 1'b0;
    logic       adc_ack = 1'b0;
    logic [3:0] field;
    logic [4:0] cnt_RF;
    logic       adc_trig;
    logic       rf_done;
    logic       err_timeout;

    rf_sequencer #(
        .DWELL_FRAMES(2),
        .ACK_TIMEOUT (255),
        .SAMPLE_ST   (2'b01)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_state   (key_state),
        .system_state(system_state),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_wdata   (tbl_wdata),
        .frame_done  (frame_done),
        .adc_ack     (adc_ack),
        .field       (field),
        .cnt_RF      (cnt_RF),
        .adc_trig    (adc_trig),
        .rf_done     (rf_done),
        .err_timeout (err_timeout)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int trig_seen = 0;
    int done_seen = 0;
    int fd_period = 0;
    bit auto_ack = 1'b0;
    logic [8:0] exp_trig_q[$];
    int exp_done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic write_tbl(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        tbl_we = 1'b1;
        tbl_addr = a;
        tbl_wdata = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic set_active(input bit on);
        key_state = on;
        system_state = on ? 2'b01 : 2'b00;
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rf_done && n < limit);
        if (!rf_done) bound_fail(name);
    endtask

    task automatic wait_cnt(input logic [4:0] v, input int limit, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cnt_RF !== v && n < limit);
        if (cnt_RF !== v) bound_fail(name);
    endtask

    // Monitor: every adc_trig / rf_done pulse is matched against the queued expectation.
    initial begin
        logic [8:0] e;
        int d;
        forever begin
            @(negedge clk);
            if (rst_n && adc_trig) begin
                trig_seen++;
                if (exp_trig_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_trig: got cnt_RF=%0d field=%0h, expected none", cnt_RF, field);
                end else begin
                    e = exp_trig_q.pop_front();
                    check("trig_cnt_field", {cnt_RF, field}, e);
                end
            end
            if (rst_n && rf_done) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rf_done: got cnt_RF=%0d, expected none", cnt_RF);
                end else begin
                    d = exp_done_q.pop_front();
                    check("rf_done_cnt", cnt_RF, d);
                    check("rf_done_field", field, 0);
                end
            end
        end
    end

    initial begin
        int c = 0;
        forever begin
            @(negedge clk);
            if (fd_period == 0) begin
                c = 0;
                frame_done = 1'b0;
            end else if (fd_period > 0) begin
                c++;
                if (c >= fd_period) begin
                    c = 0;
                    frame_done = 1'b1;
                end else begin
                    frame_done = 1'b0;
                end
            end
        end
    end

    initial begin
        int d = 0;
        forever begin
            @(negedge clk);
            adc_ack = 1'b0;
            if (d > 0) begin
                d--;
                if (d == 0) adc_ack = 1'b1;
            end
            if (auto_ack && rst_n && adc_trig) d = 3;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int t0;
        int d0;
        int n;
        int first_idx;

        repeat (3) @(negedge clk);
        check("reset_field", field, 0);
        check("reset_cnt", cnt_RF, 0);
        check("reset_trig", adc_trig, 0);
        check("reset_done", rf_done, 0);
        check("reset_err", err_timeout, 0);
        rst_n = 1'b1;

        // Table load, plus a write attempt during the scan that must be ignored.
        for (int i = 0; i < 16; i++) write_tbl(4'(i), 4'(i));
        for (int i = 0; i < 16; i++) begin
`ifdef RF_SKIP_ZERO_EN
            if (i != 0) exp_trig_q.push_back({5'(i), 4'(i)});
`else
            exp_trig_q.push_back({5'(i), 4'(i)});
`endif
        end
        exp_done_q.push_back(16);
        fd_period = 81;
        auto_ack = 1'b1;
        t0 = trig_seen;
        d0 = done_seen;
        @(negedge clk);
        set_active(1'b1);
        @(negedge clk);
        check("first_field", field, 0);
        check("first_cnt", cnt_RF, 0);
        write_tbl(4'd3, 4'hF);
        wait_done(20000, "scan1_done");
        @(negedge clk);
`ifdef RF_SKIP_ZERO_EN
        check("scan1_trig_count", trig_seen - t0, 15);
`else
        check("scan1_trig_count", trig_seen - t0, 16);
`endif
        repeat (5) @(negedge clk);
        check("scan1_done_count", done_seen - d0, 1);
        check("scan1_cnt_hold", cnt_RF, 16);
        check("scan1_field_hold", field, 0);
        check("scan1_err", err_timeout, 0);
        set_active(1'b0);
        fd_period = 0;
        auto_ack = 1'b0;
        @(negedge clk);
        check("idle_cnt", cnt_RF, 0);
        write_tbl(4'd3, 4'hF);

        // Dwell count with hand-placed frame_done pulses.
        fd_period = -1;
        frame_done = 1'b0;
`ifdef RF_SKIP_ZERO_EN
        exp_trig_q.push_back({5'd1, 4'd1});
`else
        exp_trig_q.push_back({5'd0, 4'd0});
`endif
        @(negedge clk);
        set_active(1'b1);
        repeat (3) @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        check("no_trig_after_frame1", adc_trig, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_trig_between_frames", adc_trig, 0);
        end
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        check("trig_after_frame2", adc_trig, 1);
        set_active(1'b0);
        @(negedge clk);
        check("dwell_abort_cnt", cnt_RF, 0);
        fd_period = 0;

        // Timeout on every field; tbl[3] now holds the idle write.
        for (int i = 0; i < 16; i++) begin
`ifdef RF_SKIP_ZERO_EN
            if (i != 0) exp_trig_q.push_back({5'(i), (i == 3) ? 4'hF : 4'(i)});
`else
            exp_trig_q.push_back({5'(i), (i == 3) ? 4'hF : 4'(i)});
`endif
        end
        exp_done_q.push_back(16);
`ifdef RF_SKIP_ZERO_EN
        first_idx = 1;
`else
        first_idx = 0;
`endif
        fd_period = 81;
        @(negedge clk);
        set_active(1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_trig && n < 1000);
        if (!adc_trig) bound_fail("tmo_first_trig");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 400);
        check("trig_to_err_cycles", n, 256);
        @(negedge clk);
        check("tmo_advance_cnt", cnt_RF, first_idx + 1);
        wait_done(20000, "scan_tmo_done");
        @(negedge clk);
        check("tmo_err_sticky_done", err_timeout, 1);
        set_active(1'b0);
        fd_period = 0;
        @(negedge clk);
        check("tmo_err_kept_idle", err_timeout, 1);
        check("tmo_idle_cnt", cnt_RF, 0);

        // Abort at cnt_RF == 7, then restart from tbl[0].
        for (int i = 0; i < 16; i++) write_tbl(4'(i), 4'(15 - i));
        for (int i = 0; i < 7; i++) exp_trig_q.push_back({5'(i), 4'(15 - i)});
        fd_period = 5;
        auto_ack = 1'b1;
        @(negedge clk);
        set_active(1'b1);
        @(negedge clk);
        check("entry_err_cleared", err_timeout, 0);
        check("abort_first_field", field, 15);
        wait_cnt(5'd7, 2000, "abort_reach7");
        key_state = 1'b0;
        @(negedge clk);
        check("abort_cnt", cnt_RF, 0);
        check("abort_field", field, 0);
        check("abort_trigs_consumed", exp_trig_q.size(), 0);
        key_state = 1'b1;
        @(negedge clk);
        key_state = 1'b0;
        check("restart_field", field, 15);
        check("restart_cnt", cnt_RF, 0);
        set_active(1'b0);
        fd_period = 0;
        auto_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Single non-zero entry.
        for (int i = 0; i < 16; i++) write_tbl(4'(i), (i == 5) ? 4'hA : 4'h0);
`ifdef RF_SKIP_ZERO_EN
        exp_trig_q.push_back({5'd5, 4'hA});
`else
        for (int i = 0; i < 16; i++) exp_trig_q.push_back({5'(i), (i == 5) ? 4'hA : 4'h0});
`endif
        exp_done_q.push_back(16);
        fd_period = 5;
        auto_ack = 1'b1;
        t0 = trig_seen;
        @(negedge clk);
        set_active(1'b1);
        wait_done(5000, "skip_scan_done");
        @(negedge clk);
`ifdef RF_SKIP_ZERO_EN
        check("skip_trig_count", trig_seen - t0, 1);
`else
        check("skip_trig_count", trig_seen - t0, 16);
`endif
        set_active(1'b0);
        fd_period = 0;
        auto_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-scan clears outputs and the table.
        write_tbl(4'd0, 4'h9);
        @(negedge clk);
        set_active(1'b1);
        @(negedge clk);
        check("pre_reset_field", field, 9);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_field", field, 0);
        check("async_reset_cnt", cnt_RF, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_active(1'b0);
        check("post_reset_table_cleared", field, 0);
        repeat (3) @(negedge clk);

        check("trig_queue_drained", exp_trig_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
